// File: rtl/pe_dataflow_sequencer.sv
// Run sequencer for a PE array: loads weights once, then per block loads partial sums
// and inputs, waits out the compute pipeline and drains results.
module pe_dataflow_sequencer #(
    parameter int W_PEGroupSize   = 4,
    parameter int O_PEGroupSize   = 4,
    parameter int I_PEGroupSize   = W_PEGroupSize + O_PEGroupSize - 1,
    parameter int BlockCount      = 4,
    parameter int ComputeLatency  = 4,
    parameter int BeatCountWidth  = 3,
    parameter int BlockCountWidth = 3
) (
    input  logic       clk,
    input  logic       aclr_n,
    input  logic       clk_en,
    input  logic       sclr,
    input  logic       start,
    input  logic       w_valid,
    input  logic       i_valid,
    input  logic       o_in_valid,
    input  logic       o_out_ready,
    input  logic       O_IN_BLOCK_EQUAL_TO_ZERO,
    input  logic       O_IN_BLOCK_MORE_THAN_BLOCK_COUNT,
    output logic       w_ready,
    output logic       i_ready,
    output logic       o_in_ready,
    output logic       EN_W,
    output logic       EN_I,
    output logic       EN_O_In,
    output logic       EN_O_Out,
    output logic       busy,
    output logic       done,
    output logic       err_sync,
    output logic [2:0] state_dbg
);

    // state   | meaning
    // IDLE    | waiting for start
    // LOAD_W  | weight beats, once per run
    // LOAD_O  | partial-sum beats into the current block
    // LOAD_I  | input beats for the current block
    // COMPUTE | fixed wait for the PE pipeline, no strobes
    // DRAIN   | result beats out of the current block
    // DONE    | one-cycle completion pulse
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD_W  = 3'd1;
    localparam logic [2:0] S_LOAD_O  = 3'd2;
    localparam logic [2:0] S_LOAD_I  = 3'd3;
    localparam logic [2:0] S_COMPUTE = 3'd4;
    localparam logic [2:0] S_DRAIN   = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    localparam logic [BeatCountWidth-1:0]  W_LAST   = BeatCountWidth'(W_PEGroupSize - 1);
    localparam logic [BeatCountWidth-1:0]  O_LAST   = BeatCountWidth'(O_PEGroupSize - 1);
    localparam logic [BeatCountWidth-1:0]  I_LAST   = BeatCountWidth'(I_PEGroupSize - 1);
    localparam logic [BeatCountWidth-1:0]  C_LAST   = BeatCountWidth'(ComputeLatency - 1);
    localparam logic [BlockCountWidth-1:0] BLK_LAST = BlockCountWidth'(BlockCount - 1);

    logic [2:0]                 state_q, state_d;
    logic [BeatCountWidth-1:0]  beat_q, beat_d;
    logic [BlockCountWidth-1:0] block_q, block_d;
    logic                       err_q, err_d;
    logic                       first_o_beat;

    assign w_ready    = (state_q == S_LOAD_W);
    assign o_in_ready = (state_q == S_LOAD_O);
    assign i_ready    = (state_q == S_LOAD_I);

    assign EN_W     = clk_en & (state_q == S_LOAD_W) & w_valid;
    assign EN_O_In  = clk_en & (state_q == S_LOAD_O) & o_in_valid;
    assign EN_I     = clk_en & (state_q == S_LOAD_I) & i_valid;
    assign EN_O_Out = clk_en & (state_q == S_DRAIN) & o_out_ready;

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign err_sync  = err_q;
    assign state_dbg = state_q;

    // Edge controller must report block zero when the first partial sum of a run arrives.
    assign first_o_beat = EN_O_In & (beat_q == '0) & (block_q == '0);

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        block_d = block_q;
        err_d   = err_q;
        if (clk_en) begin
            if (sclr) begin
                state_d = S_IDLE;
                beat_d  = '0;
                block_d = '0;
                err_d   = 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            state_d = S_LOAD_W;
                            beat_d  = '0;
                            block_d = '0;
                        end
                    end
                    S_LOAD_W: begin
                        if (EN_W) begin
                            if (beat_q == W_LAST) begin
                                state_d = S_LOAD_O;
                                beat_d  = '0;
                            end else begin
                                beat_d = beat_q + 1'b1;
                            end
                        end
                    end
                    S_LOAD_O: begin
                        if (EN_O_In) begin
                            if (beat_q == O_LAST) begin
                                state_d = S_LOAD_I;
                                beat_d  = '0;
                            end else begin
                                beat_d = beat_q + 1'b1;
                            end
                        end
                    end
                    S_LOAD_I: begin
                        if (EN_I) begin
                            if (beat_q == I_LAST) begin
                                state_d = S_COMPUTE;
                                beat_d  = '0;
                            end else begin
                                beat_d = beat_q + 1'b1;
                            end
                        end
                    end
                    S_COMPUTE: begin
                        if (beat_q == C_LAST) begin
                            state_d = S_DRAIN;
                            beat_d  = '0;
                        end else begin
                            beat_d = beat_q + 1'b1;
                        end
                    end
                    S_DRAIN: begin
                        if (EN_O_Out) begin
                            if (beat_q == O_LAST) begin
                                beat_d = '0;
                                if (block_q == BLK_LAST) begin
                                    state_d = S_DONE;
                                end else begin
                                    state_d = S_LOAD_O;
                                    block_d = block_q + 1'b1;
                                end
                            end else begin
                                beat_d = beat_q + 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        state_d = S_IDLE;
                        beat_d  = '0;
                    end
                    default: begin
                        state_d = S_IDLE;
                        beat_d  = '0;
                        block_d = '0;
                    end
                endcase

                if ((state_q == S_IDLE) && start) begin
                    err_d = 1'b0;
                end else if (O_IN_BLOCK_MORE_THAN_BLOCK_COUNT ||
                             (first_o_beat && !O_IN_BLOCK_EQUAL_TO_ZERO)) begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            block_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            block_q <= block_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_pe_dataflow_sequencer.sv
// Directed bench for pe_dataflow_sequencer: phase/remaining-beat model compared every
// cycle, plus literal run-length and pulse-count expectations.
module tb_pe_dataflow_sequencer;

    localparam int NW = 4, NO = 4, NI = 7, NB = 4, CL = 4;

    logic clk, aclr_n, clk_en, sclr, start;
    logic w_valid, i_valid, o_in_valid, o_out_ready, eq0, more;
    logic w_ready, i_ready, o_in_ready, EN_W, EN_I, EN_O_In, EN_O_Out;
    logic busy, done, err_sync;
    logic [2:0] state_dbg;

    pe_dataflow_sequencer dut (
        .clk(clk), .aclr_n(aclr_n), .clk_en(clk_en), .sclr(sclr), .start(start),
        .w_valid(w_valid), .i_valid(i_valid), .o_in_valid(o_in_valid),
        .o_out_ready(o_out_ready),
        .O_IN_BLOCK_EQUAL_TO_ZERO(eq0), .O_IN_BLOCK_MORE_THAN_BLOCK_COUNT(more),
        .w_ready(w_ready), .i_ready(i_ready), .o_in_ready(o_in_ready),
        .EN_W(EN_W), .EN_I(EN_I), .EN_O_In(EN_O_In), .EN_O_Out(EN_O_Out),
        .busy(busy), .done(done), .err_sync(err_sync), .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int cyc = 0, t0 = 0;
    bit running = 0;
    int n_w, n_i, n_oi, n_oo, n_busy, n_done, n_en_off, done_rel;
    bit busy_hist[512];
    bit err_hist[512];

    always @(posedge clk) cyc <= cyc + 1;

    // Model: phase number, beats still owed in that phase, block index, sticky error.
    int m_ph, m_left, m_blk;
    bit m_err;

    always @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            m_ph <= 0; m_left <= 0; m_blk <= 0; m_err <= 0;
        end else if (clk_en) begin
            if (sclr) begin
                m_ph <= 0; m_left <= 0; m_blk <= 0; m_err <= 0;
            end else begin
                case (m_ph)
                    0: if (start) begin m_ph <= 1; m_left <= NW; m_blk <= 0; end
                    1: if (w_valid) begin
                           if (m_left == 1) begin m_ph <= 2; m_left <= NO; end
                           else m_left <= m_left - 1;
                       end
                    2: if (o_in_valid) begin
                           if (m_left == 1) begin m_ph <= 3; m_left <= NI; end
                           else m_left <= m_left - 1;
                       end
                    3: if (i_valid) begin
                           if (m_left == 1) begin m_ph <= 4; m_left <= CL; end
                           else m_left <= m_left - 1;
                       end
                    4: if (m_left == 1) begin m_ph <= 5; m_left <= NO; end
                       else m_left <= m_left - 1;
                    5: if (o_out_ready) begin
                           if (m_left == 1) begin
                               if (m_blk + 1 < NB) begin
                                   m_ph <= 2; m_left <= NO; m_blk <= m_blk + 1;
                               end else m_ph <= 6;
                           end else m_left <= m_left - 1;
                       end
                    default: m_ph <= 0;
                endcase
                if (m_ph == 0 && start) m_err <= 0;
                else if (more || (m_ph == 2 && o_in_valid && m_blk == 0 && m_left == NO && !eq0))
                    m_err <= 1;
            end
        end
    end

    function automatic logic [12:0] exp_out();
        logic [12:0] v;
        v = {3'(m_ph), m_ph != 0, m_ph == 6, m_err, m_ph == 1, m_ph == 3, m_ph == 2,
             clk_en && m_ph == 1 && w_valid, clk_en && m_ph == 3 && i_valid,
             clk_en && m_ph == 2 && o_in_valid, clk_en && m_ph == 5 && o_out_ready};
        return v;
    endfunction

    function automatic logic [12:0] act_out();
        return {state_dbg, busy, done, err_sync, w_ready, i_ready, o_in_ready,
                EN_W, EN_I, EN_O_In, EN_O_Out};
    endfunction

    always @(negedge clk) begin
        logic [12:0] e, a;
        int r;
        e = exp_out();
        a = act_out();
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL outputs cyc=%0d actual=%b required=%b", cyc, a, e);
        end
        if (running) begin
            r = cyc - t0;
            if (r >= 0 && r < 512) begin busy_hist[r] = busy; err_hist[r] = err_sync; end
            n_w += int'(EN_W); n_i += int'(EN_I); n_oi += int'(EN_O_In); n_oo += int'(EN_O_Out);
            n_busy += int'(busy); n_done += int'(done);
            if (!clk_en && (EN_W || EN_I || EN_O_In || EN_O_Out)) n_en_off++;
            if (done && done_rel < 0) done_rel = r;
        end
    end

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic set_defaults();
        clk_en = 1; sclr = 0; start = 0; more = 0; eq0 = 1;
        w_valid = 1; i_valid = 1; o_in_valid = 1; o_out_ready = 1;
    endtask

    task automatic run_test(input int tid);
        bit did, tog;
        int mark, stall, r;
        did = 0; tog = 1; mark = 0; stall = 10;
        n_w = 0; n_i = 0; n_oi = 0; n_oo = 0; n_busy = 0; n_done = 0; n_en_off = 0;
        done_rel = -1;
        for (int k = 0; k < 512; k++) begin busy_hist[k] = 0; err_hist[k] = 0; end
        @(posedge clk); #1;
        start = 1; t0 = cyc; running = 1;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            r = cyc - t0;
            set_defaults();
            start = (tid == 8);
            case (tid)
                3: if (m_ph == 3 && m_blk == 0) begin i_valid = tog; tog = !tog; end
                4: if (m_ph == 5 && m_blk == 2 && stall > 0) begin o_out_ready = 0; stall--; end
                5: if (m_ph == 2 && m_blk == 0) eq0 = 0;
                9: if (r >= 30 && r <= 34) clk_en = 0;
                8: if (r >= 84) begin start = 0; sclr = (r == 84); end
                6: if (m_ph == 3 && m_blk == 1 && !did) begin sclr = 1; did = 1; mark = r; end
                7: begin
                       if (m_ph == 5 && !did) begin
                           aclr_n = 0; #1;
                           chk("reset_mid_run_outputs", int'(act_out()), 0);
                           did = 1; mark = r;
                       end else if (did && r == mark + 2) aclr_n = 1;
                   end
                default: ;
            endcase
            if (tid == 8) begin
                if (r >= 86) break;
            end else if (tid == 6 || tid == 7) begin
                if (did && r >= mark + 8) break;
            end else if (done_rel >= 0) break;
        end
        running = 0;
        set_defaults();
        aclr_n = 1;
        repeat (3) @(posedge clk);
        #1;
        case (tid)
            2: begin
                   chk("full_done_cycle", done_rel, 81);
                   chk("full_en_w", n_w, 4);
                   chk("full_en_o_in", n_oi, 16);
                   chk("full_en_i", n_i, 28);
                   chk("full_en_o_out", n_oo, 16);
                   chk("full_busy_cycles", n_busy, 81);
                   chk("full_busy_c0", int'(busy_hist[0]), 0);
                   chk("full_busy_c1", int'(busy_hist[1]), 1);
                   chk("full_done_pulses", n_done, 1);
                   chk("err_cleared_by_start", int'(err_hist[1]), 0);
               end
            3: begin
                   chk("ival_toggle_done_cycle", done_rel, 87);
                   chk("ival_toggle_en_i", n_i, 28);
               end
            4: begin
                   chk("drain_stall_done_cycle", done_rel, 91);
                   chk("drain_stall_en_o_out", n_oo, 16);
               end
            5: begin
                   chk("err_at_done", int'(err_hist[done_rel < 0 ? 0 : done_rel]), 1);
                   chk("err_done_cycle", done_rel, 81);
               end
            9: begin
                   chk("clken_done_cycle", done_rel, 86);
                   chk("clken_strobes_while_off", n_en_off, 0);
                   chk("clken_en_i", n_i, 28);
                   chk("err_cleared_next_start", int'(err_hist[1]), 0);
               end
            8: begin
                   chk("start_held_done_cycle", done_rel, 81);
                   chk("start_held_idle_after_done", int'(busy_hist[82]), 0);
                   chk("start_held_restart", int'(busy_hist[83]), 1);
               end
            6: begin
                   chk("sclr_idle_next", int'(busy_hist[mark + 1]), 0);
                   chk("sclr_no_done", n_done, 0);
               end
            7: begin
                   chk("aclr_no_done", n_done, 0);
                   chk("aclr_idle_after_release", int'(busy_hist[mark + 5]), 0);
               end
            default: ;
        endcase
    endtask

    initial begin
        set_defaults();
        aclr_n = 0;
        #3;
        chk("reset_outputs", int'(act_out()), 0);
        @(posedge clk); @(posedge clk); #1;
        aclr_n = 1;
        chk("reset_release_idle", int'(state_dbg), 0);
        @(posedge clk); #1;
        more = 1;
        @(posedge clk); #1;
        more = 0;
        chk("more_sets_err", int'(err_sync), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("err_sticky_idle", int'(err_sync), 1);

        run_test(2);
        run_test(3);
        run_test(4);
        run_test(5);
        run_test(9);
        run_test(8);
        run_test(6);
        run_test(7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pe_dataflow_sequencer.md
PE_DATAFLOW_SEQUENCER -- requirements
Module: pe_dataflow_sequencer

Interface
REQ-001 Parameter W_PEGroupSize, default 4: weight beats per run.
REQ-002 Parameter O_PEGroupSize, default 4: partial-sum beats in and out per block.
REQ-003 Parameter I_PEGroupSize, default W_PEGroupSize+O_PEGroupSize-1: input beats per block.
REQ-004 Parameter BlockCount, default 4: blocks per run.
REQ-005 Parameter ComputeLatency, default 4: wait cycles between the last input beat and the first drain beat.
REQ-006 Parameters BeatCountWidth (default 3) and BlockCountWidth (default 3): internal counter widths.
REQ-007 clk  in  1  single clock, rising edge.
REQ-008 aclr_n  in  1  asynchronous active-low reset.
REQ-009 clk_en  in  1  global clock enable; when 0, all state holds.
REQ-010 sclr  in  1  synchronous clear, qualified by clk_en.
REQ-011 start  in  1  run request, sampled in IDLE only.
REQ-012 w_valid, i_valid, o_in_valid  in  1 each  source data valid for weight, input and partial-sum streams.
REQ-013 o_out_ready  in  1  sink ready for drained outputs.
REQ-014 O_IN_BLOCK_EQUAL_TO_ZERO, O_IN_BLOCK_MORE_THAN_BLOCK_COUNT  in  1 each  status from the PE edge controller.
REQ-015 w_ready, i_ready, o_in_ready  out  1 each  high in LOAD_W, LOAD_I and LOAD_O respectively.
REQ-016 EN_W, EN_I, EN_O_In, EN_O_Out  out  1 each  per-beat strobes to the PE edge controller.
REQ-017 busy  out  1  high in any state other than IDLE.
REQ-018 done  out  1  one-cycle run-complete pulse.
REQ-019 err_sync  out  1  sticky status mismatch flag.
REQ-020 state_dbg  out  3  current state encoding.

Function
REQ-021 The block SHALL have the states IDLE=0, LOAD_W=1, LOAD_O=2, LOAD_I=3, COMPUTE=4, DRAIN=5, DONE=6.
REQ-022 The strobes SHALL be combinational and gated by clk_en:
- EN_W = LOAD_W & w_valid
- EN_O_In = LOAD_O & o_in_valid
- EN_I = LOAD_I & i_valid
- EN_O_Out = DRAIN & o_out_ready
REQ-023 In IDLE, start=1 SHALL move to LOAD_W, clear all counters and clear err_sync; start SHALL be ignored in every other state.
REQ-024 A shared beat counter SHALL increment on each strobe of the current state and reset to 0 on every state change.
REQ-025 Beat-count exits, each taken on the strobe of the final beat:
- LOAD_W -> LOAD_O after W_PEGroupSize beats
- LOAD_O -> LOAD_I after O_PEGroupSize beats
- LOAD_I -> COMPUTE after I_PEGroupSize beats
REQ-026 COMPUTE SHALL last exactly ComputeLatency cycles with all strobes low, then move to DRAIN.
REQ-027 DRAIN SHALL exit after O_PEGroupSize EN_O_Out beats:
- to LOAD_O with the block counter incremented, if block < BlockCount-1
- otherwise to DONE
REQ-028 Weights SHALL be loaded once per run; each block SHALL repeat LOAD_O, LOAD_I, COMPUTE, DRAIN.
REQ-029 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-030 A deasserted valid or ready SHALL stall the current state with no beat counted; stalls have no limit.
REQ-031 err_sync SHALL set (and stay set until start or sclr) when either condition holds:
- O_IN_BLOCK_MORE_THAN_BLOCK_COUNT=1 in any cycle
- block counter=0 and O_IN_BLOCK_EQUAL_TO_ZERO=0 on the first EN_O_In beat
REQ-032 sclr=1 with clk_en=1 SHALL force IDLE, zero all counters and clear err_sync and done, taking priority over all transitions.
REQ-033 With clk_en=0, no register SHALL change and all EN_* outputs SHALL be 0.

Reset
REQ-034 aclr_n=0 SHALL immediately force:
- state IDLE; beat and block counters 0
- busy, done and err_sync 0; all ready and EN_* outputs 0; state_dbg 0
REQ-035 Reset asserted mid-run SHALL abort the run without a done pulse; after release the block SHALL wait in IDLE for start.

Verification
REQ-036 Full run, defaults, all valids and ready held high, start pulsed at cycle 0 -> 4 EN_W, then 4x(4 EN_O_In, 7 EN_I, 4 idle, 4 EN_O_Out); done high one cycle at cycle 81; busy high for cycles 1-81.
REQ-037 i_valid toggled 1,0,1,0 during LOAD_I -> exactly 7 EN_I pulses counted; COMPUTE entered only after the 7th.
REQ-038 o_out_ready=0 for 10 cycles in the DRAIN of block 2 -> EN_O_Out low and state held in DRAIN; run completes 10 cycles later than REQ-036.
REQ-039 O_IN_BLOCK_EQUAL_TO_ZERO=0 at the first EN_O_In of block 0 -> err_sync=1 and held through done; cleared by the next start.
REQ-040 sclr pulse during LOAD_I of block 1 -> IDLE next cycle, no done; aclr_n pulse during DRAIN -> immediate IDLE with all outputs 0.
REQ-041 start held high through DONE -> a new run begins only from IDLE; clk_en=0 for 5 cycles mid-run -> all strobes 0 and completion delayed by exactly 5 cycles.
